// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the iteration-counter width helper.
package seq_divider_pkg;

    localparam int unsigned DEF_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter must count 0..2N-1, i.e. ceil(log2(2N)) bits (at least 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (2 * n <= 2) ? 1 : $clog2(2 * n);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the divider. The master issues divisions,
// the slave (the divider) reports busy/done and the results.
interface seq_divider_if #(
    parameter int N = 8
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N:0]   prem,
    input  logic         in_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   prem_next,
    output logic         q_bit
);
    // One extra bit so the shifted value never overflows before the compare.
    logic [N+1:0] shifted;

    assign shifted   = {prem, in_bit};
    assign q_bit     = (shifted >= {2'b00, divisor});
    assign prem_next = shifted[N:0] - (q_bit ? {1'b0, divisor} : '0);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, producing a
// 2N-bit quotient and N-bit remainder after a fixed 2N-cycle iteration.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned    CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   sreg;
    logic [N:0]       prem;
    logic [N-1:0]     dvsr;
    logic             dz_int;
    logic [N:0]       prem_next;
    logic             q_bit;
    logic             accept;

    logic             busy_q;
    logic             done_q;
    logic [2*N-1:0]   quotient_q;
    logic [N-1:0]     remainder_q;
    logic             dz_q;

    // A request is taken whenever the divider is not iterating (IDLE or FIN).
    assign accept = bus.start && (state != RUN);

    seq_divider_div_step #(.N(N)) u_step (
        .prem      (prem),
        .in_bit    (sreg[2*N-1]),
        .divisor   (dvsr),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // Working registers: load operands on accept, shift one step per RUN cycle.
    // NOTE: these are deliberately not reset -- every division reloads them on
    // the accepting edge, and the FSM alone decides whether their contents matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvsr   <= bus.divisor;
            sreg   <= bus.dividend;
            prem   <= '0;
            dz_int <= (bus.divisor == '0);
        end else if (state == RUN) begin
            sreg <= {sreg[2*N-2:0], q_bit};
            prem <= prem_next;
        end
    end

    // Control FSM with registered busy/done and result registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= dz_int ? '1 : {sreg[2*N-2:0], q_bit};
                        remainder_q <= dz_int ? '0 : prem_next[N-1:0];
                        dz_q        <= dz_int;
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: reset state, basic and
// extreme vectors, divide by zero, handshake timing, reset abort and a
// sampled multiplier round-trip.
module tb_seq_divider;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h (%0b) expected 0x%0h (%0b)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen; -1 if the bound expires.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    // Present a request for one edge (E0), then scramble the inputs.
    task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        tick();
        bus.start    = 1'b0;
        bus.dividend = ~dd;
        bus.divisor  = ~dv;
    endtask

    task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz);
        int lat;
        launch(dd, dv);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'd16);
        check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
        tick();
        check({tag, " done_width"}, 32'(bus.done), 32'd0);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    int a_list [8] = '{0, 1, 2, 7, 100, 128, 254, 255};
    int b_list [8] = '{1, 2, 3, 7, 16, 100, 200, 255};

    initial begin
        int lat;
        int nd;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        // Basic and extreme vectors.
        run_op("basic 1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        run_op("ffff/01", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
        run_op("ffff/ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
        run_op("0000/05", 16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        run_op("1234/00", 16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1);
        run_op("0010/04", 16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0);

        // Back-to-back: start held high from E0 through E20.
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd3;
        tick();                              // E0
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        wait_done(lat);                      // E16
        check("b2b first latency", 32'(lat), 32'd16);
        check("b2b first quotient", 32'(bus.quotient), 32'd33);
        check("b2b first remainder", 32'(bus.remainder), 32'd1);
        tick();                              // E17: accepted in FIN
        check("b2b fin accept done", 32'(bus.done), 32'd0);
        check("b2b fin accept busy", 32'(bus.busy), 32'd1);
        tick();                              // E18
        check("b2b hold quotient", 32'(bus.quotient), 32'd33);
        tick();                              // E19
        tick();                              // E20
        bus.start = 1'b0;
        wait_done(lat);                      // E33
        check("b2b second latency", 32'(lat), 32'd13);
        check("b2b second quotient", 32'(bus.quotient), 32'd142);
        check("b2b second remainder", 32'(bus.remainder), 32'd6);
        tick();
        check("b2b end done", 32'(bus.done), 32'd0);
        check("b2b end busy", 32'(bus.busy), 32'd0);

        // Start pulses at E3..E10 are ignored, not queued.
        launch(16'h0010, 8'h04);             // E0
        tick();                              // E1
        tick();                              // E2
        bus.start    = 1'b1;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'h01;
        repeat (8) tick();                   // E3..E10
        bus.start = 1'b0;
        wait_done(lat);
        check("ignore latency", 32'(lat), 32'd6);
        check("ignore quotient", 32'(bus.quotient), 32'd4);
        check("ignore remainder", 32'(bus.remainder), 32'd0);
        tick();
        check("ignore done width", 32'(bus.done), 32'd0);
        check("ignore not queued", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check("ignore idle busy", 32'(bus.busy), 32'd0);
        check("ignore hold quotient", 32'(bus.quotient), 32'd4);

        // Reset mid-run aborts without a done pulse.
        launch(16'd100, 8'd3);               // E0
        repeat (7) tick();                   // E1..E7
        check("abort mid busy", 32'(bus.busy), 32'd1);
        check("abort mid quotient", 32'(bus.quotient), 32'd4);
        rst = 1'b1;
        tick();                              // E8
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort quotient", 32'(bus.quotient), 32'd0);
        check("abort remainder", 32'(bus.remainder), 32'd0);
        check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        check("abort no done", 32'(nd), 32'd0);
        run_op("after abort 100/3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0);

        // Round-trip against multiplier products: a*b and a*b+(b-1).
        foreach (a_list[i]) begin
            foreach (b_list[j]) begin
                int a;
                int b;
                a = a_list[i];
                b = b_list[j];
                run_op($sformatf("rt %0d*%0d", a, b), 16'(a * b), 8'(b),
                       16'(a), 8'd0, 1'b0);
                run_op($sformatf("rt %0d*%0d+%0d", a, b, b - 1), 16'(a * b + b - 1), 8'(b),
                       16'(a), 8'(b - 1), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
